demux4bit1to2_capture: RTL and testbench

- Receiving end of the 4-bit 2-to-1 multiplexed bus. It takes a shared 4-bit bus plus a select and strobe, and steers each strobed word into one of two registered outputs, X or Y.
- It tracks which halves of an X/Y pair are held and flags a complete pair to a consumer, which acknowledges it.
- An optional auto mode alternates the destination internally, so a single-wire strobe stream is split X, Y, X, Y, and so on.
- It sits between the multiplexed bus and board-level consumers (LEDR/HEX display logic).

---
 rtl/demux4bit1to2_capture.sv | 81 ++++++++
 tb/tb_demux4bit1to2_capture.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/demux4bit1to2_capture.sv
// Receiving end of a 2-to-1 multiplexed bus: steers strobed words into X or Y
// and tracks X/Y pair completion for a downstream consumer.
module demux4bit1to2_capture #(
   parameter int WIDTH = 4
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [WIDTH-1:0] M,
   input  logic             s,
   input  logic             strobe,
   input  logic             auto,
   input  logic             ack,
   output logic [WIDTH-1:0] X,
   output logic [WIDTH-1:0] Y,
   output logic             pair_valid,
   output logic [1:0]       state,
   output logic             sel_next,
   output logic             overrun
);

   // Handshake: a word is accepted on every cycle strobe is high (no back-pressure);
   // a pair is offered while pair_valid is high and is retired in the cycle ack is high.

   // Encoding doubles as the held flags: bit0 = X held, bit1 = Y held.
   typedef enum logic [1:0] {
      EMPTY  = 2'b00,
      HAVE_X = 2'b01,
      HAVE_Y = 2'b10,
      FULL   = 2'b11
   } pair_state_t;

   pair_state_t cur_state;
   pair_state_t nxt_state;
   logic        toggle;
   logic        dest;
   logic        set_overrun;
   logic [1:0]  after_ack;
   logic [1:0]  dest_mask;

   assign dest     = auto ? toggle : s;
   assign sel_next = dest;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         cur_state <= EMPTY;
         X         <= '0;
         Y         <= '0;
         overrun   <= 1'b0;
         toggle    <= 1'b0;
      end else begin
         cur_state <= nxt_state;
         if (set_overrun) overrun <= 1'b1;
         if (strobe && !dest) X <= M;
         if (strobe && dest)  Y <= M;
         if (!auto)
            toggle <= 1'b0;
         else if (strobe)
            toggle <= ~toggle;
      end
   end

   // An ack in FULL is applied before a same-cycle strobe, so the strobe lands in EMPTY.
   always_comb begin
      nxt_state   = cur_state;
      set_overrun = 1'b0;
      after_ack   = cur_state;
      dest_mask   = dest ? 2'b10 : 2'b01;
      if (cur_state == FULL && ack)
         after_ack = EMPTY;
      if (strobe) begin
         set_overrun = |(after_ack & dest_mask);
         nxt_state   = pair_state_t'(after_ack | dest_mask);
      end else begin
         nxt_state   = pair_state_t'(after_ack);
      end
   end

   assign state      = cur_state;
   assign pair_valid = (cur_state == FULL);

endmodule

// File: tb/tb_demux4bit1to2_capture.sv
// Self-checking bench for demux4bit1to2_capture: expected {X,Y,state,pair_valid,overrun}
// words are queued as stimulus is driven and compared after the capturing edge.
module tb_demux4bit1to2_capture;

   logic       Clock = 1'b0;
   logic       Reset = 1'b0;
   logic [3:0] M = '0;
   logic       s = 1'b0;
   logic       strobe = 1'b0;
   logic       auto = 1'b0;
   logic       ack = 1'b0;
   logic [3:0] X;
   logic [3:0] Y;
   logic       pair_valid;
   logic [1:0] state;
   logic       sel_next;
   logic       overrun;

   logic [12:0] exp_q[$];
   int checks = 0;
   int passed = 0;

   demux4bit1to2_capture #(.WIDTH(4)) dut (
      .Clock(Clock), .Reset(Reset), .M(M), .s(s), .strobe(strobe), .auto(auto),
      .ack(ack), .X(X), .Y(Y), .pair_valid(pair_valid), .state(state),
      .sel_next(sel_next), .overrun(overrun)
   );

   always #5 Clock = ~Clock;

   function automatic logic [12:0] pack(input logic [3:0] x, input logic [3:0] y,
                                        input logic [1:0] st, input logic pv, input logic ov);
      return {x, y, st, pv, ov};
   endfunction

   // Drive one cycle of stimulus, queue its expected result, then sample #1 after the edge.
   task automatic drive(input logic r, input logic a, input logic sv, input logic [3:0] m,
                        input logic st, input logic ak, input logic [12:0] e);
      Reset = r; auto = a; s = sv; M = m; strobe = st; ack = ak;
      exp_q.push_back(e);
      @(posedge Clock); #1;
      Reset = 1'b0; strobe = 1'b0; ack = 1'b0;
   endtask

   task automatic test_reset;
      logic [12:0] got, e;
      drive(1, 0, 0, 4'h0, 0, 0, pack(4'h0, 4'h0, 2'b00, 0, 0));
      got = {X, Y, state, pair_valid, overrun}; e = exp_q.pop_front();
      checks++;
      if (got !== e) $display("FAIL reset got=%h exp=%h", got, e); else passed++;
      checks++;
      if (sel_next !== 1'b0) $display("FAIL reset_sel got=%b exp=0", sel_next); else passed++;
   endtask

   task automatic test_manual_pair;
      logic [12:0] got, e;
      drive(0, 0, 0, 4'hA, 1, 0, pack(4'hA, 4'h0, 2'b01, 0, 0));
      got = {X, Y, state, pair_valid, overrun}; e = exp_q.pop_front();
      checks++;
      if (got !== e) $display("FAIL manual_x got=%h exp=%h", got, e); else passed++;
      drive(0, 0, 1, 4'h5, 1, 0, pack(4'hA, 4'h5, 2'b11, 1, 0));
      got = {X, Y, state, pair_valid, overrun}; e = exp_q.pop_front();
      checks++;
      if (got !== e) $display("FAIL manual_y got=%h exp=%h", got, e); else passed++;
   endtask

   task automatic test_ack;
      logic [12:0] got, e;
      for (int i = 0; i < 2; i++) begin
         drive(0, 0, 0, 4'h0, 0, 1, pack(4'hA, 4'h5, 2'b00, 0, 0));
         got = {X, Y, state, pair_valid, overrun}; e = exp_q.pop_front();
         checks++;
         if (got !== e) $display("FAIL ack_%0d got=%h exp=%h", i, got, e); else passed++;
      end
   endtask

   task automatic test_auto;
      logic [12:0] got, e;
      logic [12:0] exp_tab[4];
      logic        ack_tab[4];
      logic        sel_tab[4];
      exp_tab = '{pack(4'h1, 4'h5, 2'b01, 0, 0), pack(4'h1, 4'h2, 2'b11, 1, 0),
                  pack(4'h3, 4'h2, 2'b01, 0, 0), pack(4'h3, 4'h4, 2'b11, 1, 0)};
      ack_tab = '{1'b0, 1'b0, 1'b1, 1'b0};
      sel_tab = '{1'b1, 1'b0, 1'b1, 1'b0};
      auto = 1'b1; s = 1'b1;
      #1;
      checks++;
      if (sel_next !== 1'b0) $display("FAIL auto_start_sel got=%b exp=0", sel_next); else passed++;
      for (int i = 0; i < 4; i++) begin
         drive(0, 1, 1, 4'(i + 1), 1, ack_tab[i], exp_tab[i]);
         got = {X, Y, state, pair_valid, overrun}; e = exp_q.pop_front();
         checks++;
         if (got !== e) $display("FAIL auto_%0d got=%h exp=%h", i, got, e); else passed++;
         checks++;
         if (sel_next !== sel_tab[i])
            $display("FAIL auto_sel_%0d got=%b exp=%b", i, sel_next, sel_tab[i]);
         else passed++;
      end
      drive(0, 0, 0, 4'h0, 0, 1, pack(4'h3, 4'h4, 2'b00, 0, 0));
      got = {X, Y, state, pair_valid, overrun}; e = exp_q.pop_front();
      checks++;
      if (got !== e) $display("FAIL auto_ack got=%h exp=%h", got, e); else passed++;
   endtask

   task automatic test_partial_ack;
      logic [12:0] got, e;
      drive(0, 0, 0, 4'h6, 1, 0, pack(4'h6, 4'h4, 2'b01, 0, 0));
      got = {X, Y, state, pair_valid, overrun}; e = exp_q.pop_front();
      checks++;
      if (got !== e) $display("FAIL partial_x got=%h exp=%h", got, e); else passed++;
      drive(0, 0, 0, 4'h0, 0, 1, pack(4'h6, 4'h4, 2'b01, 0, 0));
      got = {X, Y, state, pair_valid, overrun}; e = exp_q.pop_front();
      checks++;
      if (got !== e) $display("FAIL partial_ack got=%h exp=%h", got, e); else passed++;
   endtask

   task automatic test_overrun;
      logic [12:0] got, e;
      logic [12:0] exp_tab[6];
      exp_tab = '{pack(4'h0, 4'h0, 2'b00, 0, 0), pack(4'h7, 4'h0, 2'b01, 0, 0),
                  pack(4'h9, 4'h0, 2'b01, 0, 1), pack(4'h9, 4'h3, 2'b11, 1, 1),
                  pack(4'h9, 4'h3, 2'b00, 0, 1), pack(4'h0, 4'h0, 2'b00, 0, 0)};
      drive(1, 0, 0, 4'h0, 0, 0, exp_tab[0]);
      got = {X, Y, state, pair_valid, overrun}; e = exp_q.pop_front();
      checks++;
      if (got !== e) $display("FAIL ovr_reset got=%h exp=%h", got, e); else passed++;
      drive(0, 0, 0, 4'h7, 1, 0, exp_tab[1]);
      drive(0, 0, 0, 4'h9, 1, 0, exp_tab[2]);
      drive(0, 0, 1, 4'h3, 1, 0, exp_tab[3]);
      drive(0, 0, 0, 4'h0, 0, 1, exp_tab[4]);
      got = {X, Y, state, pair_valid, overrun};
      // Only the final state of the chain is visible now; the intermediate words are drained.
      for (int i = 1; i < 4; i++) void'(exp_q.pop_front());
      e = exp_q.pop_front();
      checks++;
      if (got !== e) $display("FAIL ovr_sticky got=%h exp=%h", got, e); else passed++;
      drive(1, 0, 0, 4'h0, 0, 0, exp_tab[5]);
      got = {X, Y, state, pair_valid, overrun}; e = exp_q.pop_front();
      checks++;
      if (got !== e) $display("FAIL ovr_clear got=%h exp=%h", got, e); else passed++;
   endtask

   task automatic test_full_overwrite;
      logic [12:0] got, e;
      drive(0, 0, 0, 4'h1, 1, 0, pack(4'h1, 4'h0, 2'b01, 0, 0));
      got = {X, Y, state, pair_valid, overrun}; e = exp_q.pop_front();
      checks++;
      if (got !== e) $display("FAIL fo_x got=%h exp=%h", got, e); else passed++;
      drive(0, 0, 1, 4'h2, 1, 0, pack(4'h1, 4'h2, 2'b11, 1, 0));
      got = {X, Y, state, pair_valid, overrun}; e = exp_q.pop_front();
      checks++;
      if (got !== e) $display("FAIL fo_y got=%h exp=%h", got, e); else passed++;
      drive(0, 0, 1, 4'hE, 1, 0, pack(4'h1, 4'hE, 2'b11, 1, 1));
      got = {X, Y, state, pair_valid, overrun}; e = exp_q.pop_front();
      checks++;
      if (got !== e) $display("FAIL fo_over got=%h exp=%h", got, e); else passed++;
   endtask

   task automatic test_reset_mid;
      logic [12:0] got, e;
      drive(1, 0, 0, 4'h0, 0, 0, pack(4'h0, 4'h0, 2'b00, 0, 0));
      void'(exp_q.pop_front());
      drive(0, 0, 1, 4'h8, 1, 0, pack(4'h0, 4'h8, 2'b10, 0, 0));
      got = {X, Y, state, pair_valid, overrun}; e = exp_q.pop_front();
      checks++;
      if (got !== e) $display("FAIL rm_have_y got=%h exp=%h", got, e); else passed++;
      drive(1, 1, 0, 4'hF, 1, 1, pack(4'h0, 4'h0, 2'b00, 0, 0));
      got = {X, Y, state, pair_valid, overrun}; e = exp_q.pop_front();
      checks++;
      if (got !== e) $display("FAIL rm_reset got=%h exp=%h", got, e); else passed++;
      checks++;
      if (sel_next !== 1'b0) $display("FAIL rm_sel got=%b exp=0", sel_next); else passed++;
      // Advance the toggle, then confirm Reset returns it to X while auto stays high.
      drive(0, 1, 0, 4'h3, 1, 0, pack(4'h3, 4'h0, 2'b01, 0, 0));
      got = {X, Y, state, pair_valid, overrun}; e = exp_q.pop_front();
      checks++;
      if (got !== e || sel_next !== 1'b1)
         $display("FAIL rm_toggle got=%h/%b exp=%h/1", got, sel_next, e);
      else passed++;
      drive(1, 1, 0, 4'h0, 0, 0, pack(4'h0, 4'h0, 2'b00, 0, 0));
      got = {X, Y, state, pair_valid, overrun}; e = exp_q.pop_front();
      checks++;
      if (got !== e || sel_next !== 1'b0)
         $display("FAIL rm_toggle_clr got=%h/%b exp=%h/0", got, sel_next, e);
      else passed++;
      auto = 1'b0;
   endtask

   initial begin
      @(posedge Clock); #1;
      test_reset;
      test_manual_pair;
      test_ack;
      test_auto;
      test_partial_ack;
      test_overrun;
      test_full_overwrite;
      test_reset_mid;
      checks++;
      if (exp_q.size() != 0) $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
      else passed++;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
